// File: rtl/strx_pkg.sv
// Shared definitions for the science-stream (strx) writer and reader blocks.
// Holds the frame sync header bytes, the reader FSM state encoding, a header
// byte lookup helper and a constant-evaluable ceiling-log2 helper.
package strx_pkg;

   // Sync header EB 90 00 76, also used by the writer-side control
   localparam logic [7:0] HDR0 = 8'hEB;
   localparam logic [7:0] HDR1 = 8'h90;
   localparam logic [7:0] HDR2 = 8'h00;
   localparam logic [7:0] HDR3 = 8'h76;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_PAY   = 2'd1,
      ST_FLUSH = 2'd2
   } strx_state_e;

   function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return HDR0;
         2'd1:    return HDR1;
         2'd2:    return HDR2;
         default: return HDR3;
      endcase
   endfunction

   function automatic int strx_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/strx_frame_parser_if.sv
// Payload byte stream between the frame parser and its consumer.
//   m_valid : byte valid          (master -> slave)
//   m_ready : consumer accepts    (slave -> master)
//   m_data  : payload byte        (master -> slave)
//   m_sof   : first byte of frame (master -> slave)
//   m_eof   : last byte of frame  (master -> slave)
interface strx_frame_parser_if;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_sof;
   logic       m_eof;

   modport master (output m_valid, output m_data, output m_sof, output m_eof,
                   input m_ready);
   modport slave  (input m_valid, input m_data, input m_sof, input m_eof,
                   output m_ready);
endinterface

// File: rtl/strx_idle_timer.sv
// Idle cycle counter for the frame parser.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear counter (priority over enable)
//   en_i     : count this cycle
//   tc_o     : this enabled cycle is the TIMEOUT-th consecutive one
module strx_idle_timer
   import strx_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int CW = strx_clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   assign tc_o = en_i && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr_i || tc_o) cnt_q <= '0;
      else if (en_i)            cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/strx_frame_parser.sv
// Reader end of the science-stream FIFO. Hunts for the EB 90 00 76 header and
// forwards each frame's payload with sof/eof marks. A frame closes when the
// next header arrives or the FIFO stays idle for TIMEOUT cycles.
//   clk, rst   : clock, synchronous active-high reset
//   fifo_empty : FIFO empty flag
//   fifo_rd    : FIFO pop strobe (data valid on fifo_dout the next cycle)
//   fifo_dout  : FIFO read data
//   m          : payload byte stream (master side)
//   frame_cnt  : completed frame count, wraps
module strx_frame_parser
   import strx_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNTW    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   output logic                   fifo_rd,
   input  logic [7:0]             fifo_dout,
   strx_frame_parser_if.master    m,
   output logic [CNTW-1:0]        frame_cnt
);
   strx_state_e     state_q;
   logic [1:0]      hidx_q;
   logic [7:0]      win_q [4];
   logic [2:0]      wcnt_q;
   logic            sof_pend_q;
   logic            rd_pend_q;
   logic            m_valid_q, m_sof_q, m_eof_q;
   logic [7:0]      m_data_q;
   logic [CNTW-1:0] frame_cnt_q;

   logic stall, idle_en, idle_clr, idle_tc;
   logic tail_full, tail_part;

   assign stall = m_valid_q && !m.m_ready;

   // One outstanding read; reads only when the output register will be free
   // by the time the byte arrives.
   assign fifo_rd = !rst && !fifo_empty && !rd_pend_q && !stall && (state_q != ST_FLUSH);

   // Header tail EB 90 00 sitting behind one payload byte, or alone in W
   assign tail_full = (win_q[1] == HDR0) && (win_q[2] == HDR1) && (win_q[3] == HDR2);
   assign tail_part = (win_q[0] == HDR0) && (win_q[1] == HDR1) && (win_q[2] == HDR2);

   assign idle_en  = (state_q == ST_PAY) && fifo_empty && !rd_pend_q && !stall;
   assign idle_clr = (state_q != ST_PAY) || rd_pend_q;

   strx_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle (
      .clk   (clk),
      .rst   (rst),
      .clr_i (idle_clr),
      .en_i  (idle_en),
      .tc_o  (idle_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         hidx_q      <= 2'd0;
         wcnt_q      <= 3'd0;
         sof_pend_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= 8'h00;
         m_sof_q     <= 1'b0;
         m_eof_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         rd_pend_q <= fifo_rd;
         // An accepted byte empties the register unless reloaded below
         if (m_valid_q && m.m_ready) m_valid_q <= 1'b0;

         case (state_q)
            ST_HUNT: begin
               if (rd_pend_q) begin
                  if (fifo_dout == hdr_byte(hidx_q)) begin
                     if (hidx_q == 2'd3) begin
                        state_q    <= ST_PAY;
                        sof_pend_q <= 1'b1;
                        wcnt_q     <= 3'd0;
                        hidx_q     <= 2'd0;
                     end else begin
                        hidx_q <= hidx_q + 2'd1;
                     end
                  end else begin
                     // A stray EB may itself start the header
                     hidx_q <= (fifo_dout == HDR0) ? 2'd1 : 2'd0;
                  end
               end
            end

            ST_PAY: begin
               if (rd_pend_q) begin
                  if (wcnt_q == 3'd4 && tail_full && fifo_dout == HDR3) begin
                     m_valid_q   <= 1'b1;
                     m_data_q    <= win_q[0];
                     m_sof_q     <= sof_pend_q;
                     m_eof_q     <= 1'b1;
                     sof_pend_q  <= 1'b1;
                     wcnt_q      <= 3'd0;
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                  end else if (wcnt_q == 3'd3 && tail_part && fifo_dout == HDR3) begin
                     // Empty frame: a header directly followed by another
                     wcnt_q <= 3'd0;
                  end else if (wcnt_q == 3'd4) begin
                     m_valid_q  <= 1'b1;
                     m_data_q   <= win_q[0];
                     m_sof_q    <= sof_pend_q;
                     m_eof_q    <= 1'b0;
                     sof_pend_q <= 1'b0;
                     win_q[0]   <= win_q[1];
                     win_q[1]   <= win_q[2];
                     win_q[2]   <= win_q[3];
                     win_q[3]   <= fifo_dout;
                  end else begin
                     win_q[wcnt_q[1:0]] <= fifo_dout;
                     wcnt_q             <= wcnt_q + 3'd1;
                  end
               end else if (idle_tc) begin
                  state_q <= (wcnt_q != 3'd0) ? ST_FLUSH : ST_HUNT;
               end
            end

            ST_FLUSH: begin
               if (!stall) begin
                  if (wcnt_q != 3'd0) begin
                     m_valid_q  <= 1'b1;
                     m_data_q   <= win_q[0];
                     m_sof_q    <= sof_pend_q;
                     m_eof_q    <= (wcnt_q == 3'd1);
                     sof_pend_q <= 1'b0;
                     win_q[0]   <= win_q[1];
                     win_q[1]   <= win_q[2];
                     win_q[2]   <= win_q[3];
                     wcnt_q     <= wcnt_q - 3'd1;
                  end else if (m_valid_q) begin
                     // eof byte handed over this cycle
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                     state_q     <= ST_HUNT;
                  end
               end
            end

            default: state_q <= ST_HUNT;
         endcase
      end
   end

   assign m.m_valid = m_valid_q;
   assign m.m_data  = m_data_q;
   assign m.m_sof   = m_sof_q;
   assign m.m_eof   = m_eof_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_strx_frame_parser.sv
// Directed bench for strx_frame_parser: a small FIFO model feeds bytes, a
// monitor records accepted output bytes, and each test compares them with
// hand-computed expectations.
module tb_strx_frame_parser;
   localparam int TO   = 16;
   localparam int CNTW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            fifo_empty;
   logic            fifo_rd;
   logic [7:0]      fifo_dout = 8'h00;
   logic [CNTW-1:0] frame_cnt;

   strx_frame_parser_if m_if ();

   always #5 clk = ~clk;

   strx_frame_parser #(.TIMEOUT(TO), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_dout  (fifo_dout),
      .m          (m_if.master),
      .frame_cnt  (frame_cnt)
   );

   // FIFO model
   logic [7:0] mem [0:255];
   int wp = 0;
   int rp = 0;
   assign fifo_empty = (rp == wp);
   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_dout <= mem[rp];
         rp <= rp + 1;
      end
   end

   // Output monitor: {sof, eof, data} of every accepted byte
   logic [9:0] obs [0:255];
   int no   = 0;
   int nvld = 0;
   always @(posedge clk) begin
      if (!rst && m_if.m_valid) begin
         nvld <= nvld + 1;
         if (m_if.m_ready) begin
            obs[no] <= {m_if.m_sof, m_if.m_eof, m_if.m_data};
            no <= no + 1;
         end
      end
   end

   int checks   = 0;
   int failures = 0;
   int ri       = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp] = b;
      wp = wp + 1;
   endtask

   task automatic push_hdr();
      push(8'hEB); push(8'h90); push(8'h00); push(8'h76);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ri = no;
   endtask

   task automatic wait_obs(input string tag, input int target);
      int n;
      n = 0;
      while (no < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(no), 32'(target));
   endtask

   task automatic exp_byte(input string tag, input logic sof, input logic eof, input logic [7:0] d);
      chk(tag, 32'(obs[ri]), 32'({sof, eof, d}));
      ri++;
   endtask

   logic [9:0] held;

   initial begin
      rst = 1'b1;
      m_if.m_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
      chk("rst_valid", 32'(m_if.m_valid), 32'd0);
      chk("rst_data", 32'(m_if.m_data), 32'd0);
      chk("rst_sof", 32'(m_if.m_sof), 32'd0);
      chk("rst_eof", 32'(m_if.m_eof), 32'd0);
      chk("rst_cnt", 32'(frame_cnt), 32'd0);

      // Basic frame
      do_reset();
      push_hdr();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      wait_obs("basic_len", ri + 5);
      exp_byte("basic_b0", 1'b1, 1'b0, 8'h11);
      exp_byte("basic_b1", 1'b0, 1'b0, 8'h22);
      exp_byte("basic_b2", 1'b0, 1'b0, 8'h33);
      exp_byte("basic_b3", 1'b0, 1'b0, 8'h44);
      exp_byte("basic_b4", 1'b0, 1'b1, 8'h55);
      repeat (3) @(negedge clk);
      chk("basic_cnt", 32'(frame_cnt), 32'd1);
      chk("basic_idle_valid", 32'(m_if.m_valid), 32'd0);

      // Garbage and overlapping EB before the header, single-byte frame
      do_reset();
      push(8'h00); push(8'hEB); push(8'hEB); push(8'h90); push(8'h00); push(8'h76);
      push(8'hAA);
      wait_obs("garb_len", ri + 1);
      exp_byte("garb_b0", 1'b1, 1'b1, 8'hAA);
      repeat (3) @(negedge clk);
      chk("garb_cnt", 32'(frame_cnt), 32'd1);

      // Back-to-back frames
      do_reset();
      push_hdr();
      push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
      push_hdr();
      push(8'h06);
      wait_obs("b2b_len", ri + 6);
      exp_byte("b2b_b0", 1'b1, 1'b0, 8'h01);
      exp_byte("b2b_b1", 1'b0, 1'b0, 8'h02);
      exp_byte("b2b_b2", 1'b0, 1'b0, 8'h03);
      exp_byte("b2b_b3", 1'b0, 1'b0, 8'h04);
      exp_byte("b2b_b4", 1'b0, 1'b1, 8'h05);
      exp_byte("b2b_b5", 1'b1, 1'b1, 8'h06);
      repeat (3) @(negedge clk);
      chk("b2b_cnt", 32'(frame_cnt), 32'd2);

      // Backpressure for 20 cycles mid-payload
      do_reset();
      push_hdr();
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
      wait_obs("bp_pre", ri + 2);
      begin
         int n;
         n = 0;
         while (!m_if.m_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("bp_valid_start", 32'(m_if.m_valid), 32'd1);
      m_if.m_ready = 1'b0;
      held = {m_if.m_sof, m_if.m_eof, m_if.m_data};
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_fifo_rd", 32'(fifo_rd), 32'd0);
         chk("bp_valid", 32'(m_if.m_valid), 32'd1);
         chk("bp_hold", 32'({m_if.m_sof, m_if.m_eof, m_if.m_data}), 32'(held));
      end
      m_if.m_ready = 1'b1;
      wait_obs("bp_len", ri + 10);
      exp_byte("bp_b0", 1'b1, 1'b0, 8'hA0);
      for (int i = 1; i < 9; i++) exp_byte("bp_bmid", 1'b0, 1'b0, 8'hA0 + 8'(i));
      exp_byte("bp_b9", 1'b0, 1'b1, 8'hA9);
      repeat (3) @(negedge clk);
      chk("bp_cnt", 32'(frame_cnt), 32'd1);

      // Broken header produces nothing
      do_reset();
      begin
         int v0;
         v0 = nvld;
         push(8'hEB); push(8'h90); push(8'h11); push(8'h76); push(8'h22); push(8'h33);
         repeat (60) @(negedge clk);
         chk("brk_valid_cycles", 32'(nvld), 32'(v0));
         chk("brk_bytes", 32'(no), 32'(ri));
         chk("brk_cnt", 32'(frame_cnt), 32'd0);
      end

      // Reset mid-frame
      do_reset();
      push_hdr();
      push(8'hC1); push(8'hC2); push(8'hC3);
      begin
         int n;
         n = 0;
         while (!fifo_empty && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
      chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      begin
         int v0;
         v0 = nvld;
         ri = no;
         push(8'hC4); push(8'hC5); push(8'hC6); push(8'hC7); push(8'hC8); push(8'hC9);
         repeat (60) @(negedge clk);
         chk("mid_rst_after_vld", 32'(nvld), 32'(v0));
         chk("mid_rst_after_bytes", 32'(no), 32'(ri));
         chk("mid_rst_after_cnt", 32'(frame_cnt), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
